as_seq: RTL

Multi-cycle signed add/subtract sequencer that computes a `4*NIBBLES`-bit result by running a single 4-bit nibble adder/subtractor slice once per cycle, least-significant nibble first. It sits between a requesting unit and the shared 4-bit arithmetic slice. It accepts an operand pair over a valid/ready handshake, iterates the slice with a registered carry, and returns sum/difference plus signed overflow over a second valid/ready handshake.

---
 rtl/as_seq_pkg.sv | 34 +++
 rtl/as_nibble.sv | 29 ++
 rtl/as_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/as_seq_pkg.sv
// Shared types and constants for the as_seq nibble-serial add/subtract sequencer.
// Saturation helpers build the clamp values for any data width up to MAX_W.
package as_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;
  localparam int MAX_W    = 64;

  // Largest positive two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of width w, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/as_nibble.sv
// 4-bit combinational add/subtract slice; b is inverted when sel=1 so that
// subtraction becomes a + ~b + cin. Also exposes the carry into bit 3.
module as_nibble
  import as_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sel,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                cout
);

  logic [NIBBLE_W-1:0] w_b_eff;
  logic [3:0]          w_low;
  logic [1:0]          w_high;

  assign w_b_eff = sel ? ~b : b;

  // Split at bit 3 so the carry into the MSB is visible for overflow detection.
  assign w_low  = {1'b0, a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, cin};
  assign c3     = w_low[3];
  assign w_high = {1'b0, a[3]} + {1'b0, w_b_eff[3]} + {1'b0, c3};

  assign s    = {w_high[0], w_low[2:0]};
  assign cout = w_high[1];

endmodule

// File: rtl/as_seq.sv
// Nibble-serial signed add/subtract sequencer: one as_nibble pass per cycle, LSB first.
// Define AS_SEQ_SAT_EN to clamp the result to the signed range on overflow.
module as_seq
  import as_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic                        sel,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] s,
  output logic                        o
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [W-1:0]        r_s;
  logic                r_sel;
  logic                r_carry;
  logic                r_o;
  logic [IDX_W-1:0]    r_idx;

  logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_a_cur;
  logic [NIBBLE_W-1:0] w_b_cur;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_c3;
  logic                w_cout;
  logic                w_last;
  logic                w_ovf;
  logic                w_accept;
  logic [W-1:0]        w_s_merged;
  logic [W-1:0]        w_s_final;

  // Slice operands out of the latched words and splice the new nibble into the result.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
      assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
      assign w_s_merged[gi*NIBBLE_W +: NIBBLE_W] =
        (r_idx == IDX_W'(gi)) ? w_sum : r_s[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  always_comb begin
    w_a_cur = '0;
    w_b_cur = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_cur = w_a_nib[k];
        w_b_cur = w_b_nib[k];
      end
    end
  end

  as_nibble u_nibble (
    .a    (w_a_cur),
    .b    (w_b_cur),
    .sel  (r_sel),
    .cin  (r_carry),
    .s    (w_sum),
    .c3   (w_c3),
    .cout (w_cout)
  );

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_ovf  = w_c3 ^ w_cout;

`ifdef AS_SEQ_SAT_EN
  localparam logic [MAX_W-1:0] SAT_POS_FULL = sat_pos(W);
  localparam logic [MAX_W-1:0] SAT_NEG_FULL = sat_neg(W);
  localparam logic [W-1:0]     SAT_POS      = SAT_POS_FULL[W-1:0];
  localparam logic [W-1:0]     SAT_NEG      = SAT_NEG_FULL[W-1:0];

  // Overflow implies A and the effective B share a sign, so A's sign picks the rail.
  assign w_s_final = (w_last && w_ovf) ? (r_a[W-1] ? SAT_NEG : SAT_POS) : w_s_merged;
`else
  assign w_s_final = w_s_merged;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start_valid) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)      w_state_next = ST_DONE;
      ST_DONE: if (res_ready)   w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (r_state == ST_IDLE);
    res_valid   = (r_state == ST_DONE);
  end

  assign w_accept = start_valid && start_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_sel   <= 1'b0;
      r_carry <= 1'b0;
      r_o     <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sel   <= sel;
      r_carry <= sel;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s     <= w_s_final;
      r_carry <= w_cout;
      r_idx   <= r_idx + IDX_W'(1);
      if (w_last) r_o <= w_ovf;
    end
  end

  assign s = r_s;
  assign o = r_o;

endmodule
